sequence_controller: RTL and testbench
======================================

// Module: sequence_controller
// PURPOSE
//  8-phase instruction sequencer for the 8-bit CPU. It generates the load-enable and
//  bus strobes that drive the datapath registers (ld_ir, ld_ac, ld_pc), memory (rd, wr)
//  and the address mux (sel). Instructions are decoded from the IR opcode and ALU zero flag.
//  It is the initiator side of the register enable interface: registers capture on the
//  posedge where their ld_* strobe is high.
// PARAMETERS
//  OP_HLT  3'd0  halt; OP_SKZ 3'd1 skip-if-zero; OP_ADD 3'd2; OP_AND 3'd3
//  OP_XOR  3'd4; OP_LDA 3'd5 load acc; OP_STO 3'd6 store acc; OP_JMP 3'd7 jump
// PORTS
//  clk      in   1  system clock, posedge
//  rst_     in   1  asynchronous active-low reset
//  opcode   in   3  IR[7:5]; stable from OP_ADDR through STORE
//  zero     in   1  accumulator==0 flag; sampled only in ALU_OP
//  phase    out  3  current phase (debug/observability)
//  sel      out  1  1=PC drives address bus, 0=IR operand field
//  rd       out  1  memory read enable
//  ld_ir    out  1  IR load enable
//  ld_ac    out  1  accumulator load enable
//  ld_pc    out  1  PC load enable (jump)
//  inc_pc   out  1  PC increment enable
//  wr       out  1  memory write strobe
//  data_e   out  1  accumulator drives data bus
//  halt     out  1  sticky halt indicator
// BEHAVIOUR
//  - Only the phase register (3b) and halted flag are sequential. All strobes are
//    combinational from {phase, opcode, zero, halted}, with no added latency.
//  - Reset (rst_=0, async, immediate): phase=INST_ADDR(0), halted=0. Outputs then read
//    sel=1 and all others 0.
//  - Phase order: INST_ADDR(0) -> INST_FETCH(1) -> INST_LOAD(2) -> IDLE(3) -> OP_ADDR(4)
//    -> OP_FETCH(5) -> ALU_OP(6) -> STORE(7). The phase advances by 1 each posedge and
//    wraps from 7 to 0.
//  - ALUOP = opcode in {ADD, AND, XOR, LDA}.
//  - Strobes per phase (any strobe not listed is 0):
//      INST_ADDR  : sel
//      INST_FETCH : sel, rd
//      INST_LOAD  : sel, rd, ld_ir
//      IDLE       : sel, rd, ld_ir
//      OP_ADDR    : inc_pc=!HLT; halt=HLT
//      OP_FETCH   : rd=ALUOP
//      ALU_OP     : rd=ALUOP, inc_pc=(SKZ&&zero), ld_pc=JMP, data_e=STO
//      STORE      : rd=ALUOP, ld_ac=ALUOP, inc_pc=JMP, ld_pc=JMP, wr=STO, data_e=STO
//  - Halt: at a posedge in OP_ADDR with opcode=HLT, halted is set to 1 and the phase
//    freezes at OP_ADDR.
//    * While halted: halt=1 and every other strobe is 0, including inc_pc. zero and
//      opcode are ignored.
//    * Only rst_ clears halted. The halt output is 1 in OP_ADDR+HLT combinationally and
//      from then on is held high by the flag.
//  - wr and ld_ac are never both 1. ld_ir is only ever 1 with sel=1.
//  - SKZ with zero=0 gives exactly one inc_pc (OP_ADDR). With zero=1 it gives two.
//  - Reset asserted mid-instruction, in any phase: outputs go to their reset values in
//    the same cycle with no clock edge. After rst_ deasserts, the first posedge moves the
//    phase to INST_FETCH.
// TESTING
//  1. ADD (op=2), zero=0, 8 clocks from reset. Per phase: sel 11110000; rd 01110111;
//     ld_ir 00110000; inc_pc 00001000; ld_ac 00000001; all other strobes 0.
//  2. SKZ (op=1): with zero=1, inc_pc=1 in OP_ADDR and ALU_OP. With zero=0, inc_pc=1
//     only in OP_ADDR. rd=0 in phases 5-7.
//  3. STO (op=6): data_e=1 in ALU_OP and STORE; wr=1 only in STORE; ld_ac=0 and rd=0
//     in phases 5-7.
//  4. JMP (op=7): ld_pc=1 in ALU_OP and STORE; inc_pc=1 in OP_ADDR and STORE; wr=0.
//  5. HLT (op=0): halt=1 from OP_ADDR onward. phase stays 4 for 20 clocks with all other
//     strobes 0, even with opcode changed to 2. rst_ pulse -> phase=0, halt=0.
//  6. rst_ driven low between edges in ALU_OP with op=7 -> ld_pc drops, phase=0 and sel=1
//     immediately. After release, the next posedge gives phase=1 and rd=1.

Source files
------------

// File: rtl/sequence_controller.sv
// 8-phase instruction sequencer for the 8-bit CPU: drives register load enables,
// memory strobes and the address mux from {phase, opcode, zero, halted}.
module sequence_controller #(
   parameter logic [2:0] OP_HLT = 3'd0,
   parameter logic [2:0] OP_SKZ = 3'd1,
   parameter logic [2:0] OP_ADD = 3'd2,
   parameter logic [2:0] OP_AND = 3'd3,
   parameter logic [2:0] OP_XOR = 3'd4,
   parameter logic [2:0] OP_LDA = 3'd5,
   parameter logic [2:0] OP_STO = 3'd6,
   parameter logic [2:0] OP_JMP = 3'd7
) (
   input  logic       clk,
   input  logic       rst_,
   input  logic [2:0] opcode,
   input  logic       zero,
   output logic [2:0] phase,
   output logic       sel,
   output logic       rd,
   output logic       ld_ir,
   output logic       ld_ac,
   output logic       ld_pc,
   output logic       inc_pc,
   output logic       wr,
   output logic       data_e,
   output logic       halt
);

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   phase_t phase_q, phase_d;
   logic   halted_q, halted_d;
   logic   is_hlt, is_skz, is_sto, is_jmp, is_aluop;

   assign is_hlt   = (opcode == OP_HLT);
   assign is_skz   = (opcode == OP_SKZ);
   assign is_sto   = (opcode == OP_STO);
   assign is_jmp   = (opcode == OP_JMP);
   assign is_aluop = (opcode == OP_ADD) || (opcode == OP_AND) ||
                     (opcode == OP_XOR) || (opcode == OP_LDA);

   assign phase = phase_q;

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         phase_q  <= INST_ADDR;
         halted_q <= 1'b0;
      end else begin
         phase_q  <= phase_d;
         halted_q <= halted_d;
      end
   end

   always_comb begin
      phase_d  = phase_t'(phase_q + 3'd1);
      halted_d = halted_q;
      sel      = 1'b0;
      rd       = 1'b0;
      ld_ir    = 1'b0;
      ld_ac    = 1'b0;
      ld_pc    = 1'b0;
      inc_pc   = 1'b0;
      wr       = 1'b0;
      data_e   = 1'b0;
      halt     = 1'b0;
      if (halted_q) begin
         // Frozen until reset; opcode and zero no longer matter.
         phase_d = phase_q;
         halt    = 1'b1;
      end else begin
         case (phase_q)
            INST_ADDR: sel = 1'b1;
            INST_FETCH: begin
               sel = 1'b1;
               rd  = 1'b1;
            end
            INST_LOAD, IDLE: begin
               sel   = 1'b1;
               rd    = 1'b1;
               ld_ir = 1'b1;
            end
            OP_ADDR: begin
               if (is_hlt) begin
                  halt     = 1'b1;
                  halted_d = 1'b1;
                  phase_d  = phase_q;
               end else begin
                  inc_pc = 1'b1;
               end
            end
            OP_FETCH: rd = is_aluop;
            ALU_OP: begin
               rd     = is_aluop;
               inc_pc = is_skz & zero;
               ld_pc  = is_jmp;
               data_e = is_sto;
            end
            STORE: begin
               rd     = is_aluop;
               ld_ac  = is_aluop;
               inc_pc = is_jmp;
               ld_pc  = is_jmp;
               wr     = is_sto;
               data_e = is_sto;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sequence_controller.sv
// Bench for sequence_controller: per-opcode phase tables, halt and async-reset
// sequences, then randomized traffic against a rule-based reference model.
module tb_sequence_controller;

   logic       clk;
   logic       rst_;
   logic [2:0] opcode;
   logic       zero;
   logic [2:0] phase;
   logic       sel, rd, ld_ir, ld_ac, ld_pc, inc_pc, wr, data_e, halt;

   int total = 0;
   int bad   = 0;

   sequence_controller dut (
      .clk    (clk),
      .rst_   (rst_),
      .opcode (opcode),
      .zero   (zero),
      .phase  (phase),
      .sel    (sel),
      .rd     (rd),
      .ld_ir  (ld_ir),
      .ld_ac  (ld_ac),
      .ld_pc  (ld_pc),
      .inc_pc (inc_pc),
      .wr     (wr),
      .data_e (data_e),
      .halt   (halt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e, halt}
   logic [8:0] obs;
   assign obs = {sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e, halt};

   localparam logic [8:0] RST_OUT  = 9'b1_0000_0000;
   localparam logic [8:0] HALT_OUT = 9'b0_0000_0001;

   // Patterns are written phase 0 first (MSB) to phase 7 (LSB).
   typedef struct packed {
      logic [2:0] op;
      logic       zero;
      logic [7:0] sel, rd, ld_ir, inc_pc, ld_ac, ld_pc, wr, data_e;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, got, want);
      end
   endtask

   task automatic do_reset(input logic [2:0] op, input logic z);
      @(negedge clk);
      opcode = op;
      zero   = z;
      rst_   = 1'b0;
      #2;
      check("reset_phase", 16'(phase), 16'd0);
      check("reset_out", 16'(obs), 16'(RST_OUT));
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   function automatic logic [8:0] model_out(int ph, logic [2:0] op, logic z, logic h);
      logic aluop;
      logic [8:0] o;
      aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
      if (h) return HALT_OUT;
      o[8] = (ph < 4);
      o[7] = (ph >= 1 && ph <= 3) || (ph >= 5 && aluop);
      o[6] = (ph == 2 || ph == 3);
      o[5] = (ph == 4 && op != 3'd0) || (ph == 6 && op == 3'd1 && z) || (ph == 7 && op == 3'd7);
      o[4] = (ph == 7 && aluop);
      o[3] = (ph >= 6 && op == 3'd7);
      o[2] = (ph == 7 && op == 3'd6);
      o[1] = (ph >= 6 && op == 3'd6);
      o[0] = (ph == 4 && op == 3'd0);
      return o;
   endfunction

   initial begin
      vec_t v;
      logic [8:0] exp_o;
      int m_ph;
      logic m_h;

      //            op    z     sel          rd           ld_ir        inc_pc       ld_ac        ld_pc        wr           data_e
      vecs[0] = '{3'd2, 1'b0, 8'b11110000, 8'b01110111, 8'b00110000, 8'b00001000, 8'b00000001, 8'b00000000, 8'b00000000, 8'b00000000};
      vecs[1] = '{3'd1, 1'b1, 8'b11110000, 8'b01110000, 8'b00110000, 8'b00001010, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000};
      vecs[2] = '{3'd1, 1'b0, 8'b11110000, 8'b01110000, 8'b00110000, 8'b00001000, 8'b00000000, 8'b00000000, 8'b00000000, 8'b00000000};
      vecs[3] = '{3'd6, 1'b0, 8'b11110000, 8'b01110000, 8'b00110000, 8'b00001000, 8'b00000000, 8'b00000000, 8'b00000001, 8'b00000011};
      vecs[4] = '{3'd7, 1'b1, 8'b11110000, 8'b01110000, 8'b00110000, 8'b00001001, 8'b00000000, 8'b00000011, 8'b00000000, 8'b00000000};
      vecs[5] = '{3'd3, 1'b1, 8'b11110000, 8'b01110111, 8'b00110000, 8'b00001000, 8'b00000001, 8'b00000000, 8'b00000000, 8'b00000000};
      vecs[6] = '{3'd4, 1'b0, 8'b11110000, 8'b01110111, 8'b00110000, 8'b00001000, 8'b00000001, 8'b00000000, 8'b00000000, 8'b00000000};
      vecs[7] = '{3'd5, 1'b1, 8'b11110000, 8'b01110111, 8'b00110000, 8'b00001000, 8'b00000001, 8'b00000000, 8'b00000000, 8'b00000000};

      rst_   = 1'b0;
      opcode = 3'd0;
      zero   = 1'b0;

      // Table: one full instruction per opcode, phase by phase from reset.
      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         do_reset(v.op, v.zero);
         for (int p = 0; p < 8; p++) begin
            #1;
            exp_o = {v.sel[7-p], v.rd[7-p], v.ld_ir[7-p], v.inc_pc[7-p], v.ld_ac[7-p],
                     v.ld_pc[7-p], v.wr[7-p], v.data_e[7-p], 1'b0};
            check($sformatf("vec%0d_ph%0d_phase", i, p), 16'(phase), 16'(p));
            check($sformatf("vec%0d_ph%0d_out", i, p), 16'(obs), 16'(exp_o));
            @(negedge clk);
         end
         #1;
         check($sformatf("vec%0d_wrap", i), 16'(phase), 16'd0);
      end

      // Halt: sticky, phase frozen at OP_ADDR, inputs ignored, cleared only by reset.
      do_reset(3'd0, 1'b0);
      for (int p = 0; p < 4; p++) @(negedge clk);
      #1;
      check("hlt_enter_phase", 16'(phase), 16'd4);
      check("hlt_enter_out", 16'(obs), 16'(HALT_OUT));
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 5) begin
            opcode = 3'd2;
            zero   = 1'b1;
         end
         if (k == 12) opcode = 3'd7;
         #1;
         check($sformatf("hlt_hold%0d_phase", k), 16'(phase), 16'd4);
         check($sformatf("hlt_hold%0d_out", k), 16'(obs), 16'(HALT_OUT));
      end
      rst_ = 1'b0;
      #1;
      check("hlt_rst_phase", 16'(phase), 16'd0);
      check("hlt_rst_out", 16'(obs), 16'(RST_OUT));
      @(negedge clk);
      rst_ = 1'b1;
      @(negedge clk);
      #1;
      check("hlt_after_phase", 16'(phase), 16'd1);
      check("hlt_after_halt", 16'(halt), 16'd0);

      // Async reset in the middle of a JMP.
      do_reset(3'd7, 1'b0);
      for (int p = 0; p < 6; p++) @(negedge clk);
      #1;
      check("jmp_alu_ld_pc", 16'(ld_pc), 16'd1);
      #1;
      rst_ = 1'b0;
      #1;
      check("jmp_rst_ld_pc", 16'(ld_pc), 16'd0);
      check("jmp_rst_phase", 16'(phase), 16'd0);
      check("jmp_rst_sel", 16'(sel), 16'd1);
      #1;
      rst_ = 1'b1;
      @(posedge clk);
      #1;
      check("jmp_rel_phase", 16'(phase), 16'd1);
      check("jmp_rel_rd", 16'(rd), 16'd1);

      // Randomized traffic against the reference model.
      do_reset(3'd2, 1'b0);
      m_ph = 0;
      m_h  = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if (i != 0) @(negedge clk);
         if (m_h) rst_ = ($urandom_range(0, 4) != 0);
         else     rst_ = ($urandom_range(0, 40) != 0);
         if (m_h || m_ph == 0) begin
            if ($urandom_range(0, 9) == 0) opcode = 3'd0;
            else                           opcode = 3'($urandom_range(1, 7));
         end
         zero = 1'($urandom_range(0, 1));
         if (!rst_) begin
            m_ph = 0;
            m_h  = 1'b0;
         end
         #1;
         check($sformatf("rnd%0d_phase", i), 16'(phase), 16'(m_ph));
         check($sformatf("rnd%0d_out", i), 16'(obs), 16'(model_out(m_ph, opcode, zero, m_h)));
         check($sformatf("rnd%0d_wr_ld_ac", i), 16'(wr & ld_ac), 16'd0);
         @(posedge clk);
         if (rst_ && !m_h) begin
            if (m_ph == 4 && opcode == 3'd0) m_h = 1'b1;
            else                             m_ph = (m_ph + 1) % 8;
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
